// File: rtl/regfile_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared constants and types for the register-file write-port controller.
//   NREG    : number of architectural registers
//   AW / DW : register address / data widths
//   state_t : controller state (CLEAR sequence or normal arbitration)
// ---------------------------------------------------------------------------
package regfile_ctrl_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after (ptr+1) mod NREQ wins.
//   req    in  NREQ  request vector
//   ptr    in  IW    index of the most recently served requester
//   enable in  1     0 forces no grant
//   gnt    out NREQ  one-hot grant (all zero when nothing granted)
//   idx    out IW    encoded index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    int   cand;
    logic found;

    // Walk the requesters starting just after the pointer; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (enable && !found && req[IW'(cand)]) begin
                gnt[IW'(cand)] = 1'b1;
                idx            = IW'(cand);
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the single write port of the 32x32 register file among NREQ
// writeback requesters (round-robin, valid/ready) and runs a clear sequence
// that writes zero to every register after reset and on clr_start.
//   clk, rst   clock / asynchronous active-high reset
//   req_valid  in  NREQ      write pending per requester
//   req_addr   in  NREQ*5    register number, slice [5i+4:5i]
//   req_data   in  NREQ*32   write data, slice [32i+31:32i]
//   req_ready  out NREQ      one-hot grant, transfer on valid&ready
//   clr_start  in  1         request a full clear
//   waddr/wdata/w_en out     registered register-file write port
//   busy       out 1         clear sequence running
//   clr_done   out 1         pulse together with the final clear write
// ---------------------------------------------------------------------------
module regfile_wr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               clr_start,
    output logic [AW-1:0]      waddr,
    output logic [DW-1:0]      wdata,
    output logic               w_en,
    output logic               busy,
    output logic               clr_done
);

    localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam state_t          RST_STATE = CLEAR_ON_RESET ? CLEAR : ARB;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NREG - 1);
    localparam logic [IW-1:0]   PTR_RST   = IW'(NREQ - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;

    logic            w_en_p1, w_en_d;
    logic [AW-1:0]   waddr_p1, waddr_d;
    logic [DW-1:0]   wdata_p1, wdata_d;
    logic            clr_done_p1, clr_done_d;

    logic            arb_en;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            xfer;

    // A clr_start in ARB suppresses every grant that cycle so no request is
    // accepted and then lost to the clear.
    assign arb_en = (state_q == ARB) && !clr_start;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (arb_en),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        w_en_d     = 1'b0;
        waddr_d    = waddr_p1;
        wdata_d    = wdata_p1;
        clr_done_d = 1'b0;
        case (state_q)
            ARB: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (xfer) begin
                    ptr_d   = gnt_idx;
                    // r0 is hardwired zero: accept the transfer, drop the write.
                    w_en_d  = |sel_addr;
                    waddr_d = sel_addr;
                    wdata_d = sel_data;
                end
            end
            CLEAR: begin
                w_en_d  = 1'b1;
                waddr_d = cnt_q;
                wdata_d = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    clr_done_d = 1'b1;
                    state_d    = ARB;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Stage boundary: control state and registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            ptr_q       <= PTR_RST;
            w_en_p1     <= 1'b0;
            waddr_p1    <= '0;
            wdata_p1    <= '0;
            clr_done_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            w_en_p1     <= w_en_d;
            waddr_p1    <= waddr_d;
            wdata_p1    <= wdata_d;
            clr_done_p1 <= clr_done_d;
        end
    end

    assign w_en     = w_en_p1;
    assign waddr    = waddr_p1;
    assign wdata    = wdata_p1;
    assign clr_done = clr_done_p1;
    assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int NREQ = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*5-1:0]  req_addr  = '0;
    logic [NREQ*32-1:0] req_data  = '0;
    logic [NREQ-1:0]    req_ready;
    logic               clr_start = 1'b0;
    logic [4:0]         waddr;
    logic [31:0]        wdata;
    logic               w_en;
    logic               busy;
    logic               clr_done;

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0] drv_valid = '0;
    logic [4:0]      drv_addr [NREQ];
    logic [31:0]     drv_data [NREQ];

    logic [31:0] tb_rf  [32];
    logic [31:0] exp_rf [32];
    int          m_ptr;

    regfile_wr_arbiter #(.NREQ(NREQ), .CLEAR_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .waddr     (waddr),
        .wdata     (wdata),
        .w_en      (w_en),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    // Register file behind the write port.
    always @(posedge clk) begin
        if (w_en) tb_rf[waddr] <= wdata;
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            tb_rf[i]  = 32'hBAD0_0000 | i;
            exp_rf[i] = 32'h0;
        end
        for (int i = 0; i < NREQ; i++) begin
            drv_addr[i] = '0;
            drv_data[i] = '0;
        end
    end

    // Rule: first valid requester at distance 1..NREQ after the pointer.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                int d;
                d = (i - p - 1 + 2 * NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic apply_drive();
        req_valid = drv_valid;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*5 +: 5]   = drv_addr[i];
            req_data[i*32 +: 32] = drv_data[i];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({w_en, waddr, wdata, clr_done, busy, req_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got w_en=%0b waddr=%0d wdata=%0h clr_done=%0b busy=%0b ready=%b, expected 0 0 0 0 1 000",
                     w_en, waddr, wdata, clr_done, busy, req_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({w_en, waddr, wdata, clr_done, busy} !== {1'b1, 5'(i), 32'd0, (i == 31), (i < 31)}) begin
                errors++;
                $display("FAIL reset_clear[%0d]: got w_en=%0b waddr=%0d wdata=%0h clr_done=%0b busy=%0b, expected 1 %0d 0 %0b %0b",
                         i, w_en, waddr, wdata, clr_done, busy, i, (i == 31), (i < 31));
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (tb_rf[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rf_zero[%0d]: got %0h, expected 0", i, tb_rf[i]);
            end
        end
        m_ptr = NREQ - 1;
    endtask

    task automatic test_round_robin();
        drv_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            drv_addr[i] = 5'(i + 1);
            drv_data[i] = 32'hA + i;
        end
        apply_drive();
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (req_ready !== 3'(1 << (c % 3))) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, expected %b", c, req_ready, 3'(1 << (c % 3)));
            end
            @(posedge clk); #1;
            checks++;
            if ({w_en, waddr, wdata} !== {1'b1, 5'(c % 3 + 1), 32'hA + (c % 3)}) begin
                errors++;
                $display("FAIL rr_write[%0d]: got w_en=%0b waddr=%0d wdata=%0h, expected 1 %0d %0h",
                         c, w_en, waddr, wdata, c % 3 + 1, 32'hA + (c % 3));
            end
            m_ptr = c % 3;
        end
        for (int i = 0; i < NREQ; i++) exp_rf[i + 1] = 32'hA + i;
        drv_valid = '0;
        apply_drive();
    endtask

    task automatic test_single();
        drv_valid   = 3'b100;
        drv_addr[2] = 5'd5;
        drv_data[2] = 32'hDEADBEEF;
        apply_drive();
        #1;
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL single_ready: got %b, expected 100", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({w_en, waddr, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_write: got w_en=%0b waddr=%0d wdata=%0h, expected 1 5 deadbeef", w_en, waddr, wdata);
        end
        drv_valid = '0;
        apply_drive();
        @(posedge clk); #1;
        checks++;
        if (tb_rf[5] !== 32'hDEADBEEF || w_en !== 1'b0) begin
            errors++;
            $display("FAIL single_rf: got r5=%0h w_en=%0b, expected deadbeef 0", tb_rf[5], w_en);
        end
        exp_rf[5] = 32'hDEADBEEF;
        m_ptr = 2;
    endtask

    task automatic test_addr_zero();
        drv_valid   = 3'b010;
        drv_addr[1] = 5'd0;
        drv_data[1] = 32'h1234;
        apply_drive();
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL r0_ready: got %b, expected 010", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (w_en !== 1'b0) begin
            errors++;
            $display("FAIL r0_wen: got %0b, expected 0", w_en);
        end
        drv_valid = '0;
        apply_drive();
        @(posedge clk); #1;
        checks++;
        if (tb_rf[0] !== 32'h0) begin
            errors++;
            $display("FAIL r0_value: got %0h, expected 0", tb_rf[0]);
        end
        m_ptr = 1;
    endtask

    task automatic test_clear_cmd();
        drv_valid   = 3'b001;
        drv_addr[0] = 5'd7;
        drv_data[0] = 32'h55AA;
        apply_drive();
        clr_start = 1'b1;
        #1;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL clr_start_ready: got %b, expected 000", req_ready);
        end
        @(posedge clk); #1;
        clr_start = 1'b0;
        #1;
        checks++;
        if ({busy, w_en, req_ready} !== {1'b1, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL clr_enter: got busy=%0b w_en=%0b ready=%b, expected 1 0 000", busy, w_en, req_ready);
        end
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({w_en, waddr, wdata, clr_done, req_ready} !== {1'b1, 5'(i), 32'd0, (i == 31), (i == 31) ? 3'b001 : 3'b000}) begin
                errors++;
                $display("FAIL clr_seq[%0d]: got w_en=%0b waddr=%0d wdata=%0h clr_done=%0b ready=%b",
                         i, w_en, waddr, wdata, clr_done, req_ready);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({w_en, waddr, wdata} !== {1'b1, 5'd7, 32'h55AA}) begin
            errors++;
            $display("FAIL clr_after_write: got w_en=%0b waddr=%0d wdata=%0h, expected 1 7 55aa", w_en, waddr, wdata);
        end
        drv_valid = '0;
        apply_drive();
        @(posedge clk); #1;
        checks++;
        if (tb_rf[7] !== 32'h55AA) begin
            errors++;
            $display("FAIL clr_survive: got r7=%0h, expected 55aa", tb_rf[7]);
        end
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
        exp_rf[7] = 32'h55AA;
        m_ptr = 0;
    endtask

    task automatic test_random();
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        int          g;
        for (int c = 0; c < 400; c++) begin
            apply_drive();
            #1;
            g = model_pick(drv_valid, m_ptr);
            checks++;
            if (req_ready !== ((g < 0) ? 3'b000 : 3'(1 << g))) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %b, expected index %0d (valid %b)", c, req_ready, g, drv_valid);
            end
            @(posedge clk);
            exp_wen   = 1'b0;
            exp_waddr = '0;
            exp_wdata = '0;
            if (g >= 0) begin
                m_ptr     = g;
                exp_wen   = (drv_addr[g] != 5'd0);
                exp_waddr = drv_addr[g];
                exp_wdata = drv_data[g];
                if (exp_wen) exp_rf[drv_addr[g]] = drv_data[g];
                drv_valid[g] = 1'b0;
            end
            #1;
            checks++;
            if (w_en !== exp_wen || (exp_wen && (waddr !== exp_waddr || wdata !== exp_wdata))) begin
                errors++;
                $display("FAIL rand_write[%0d]: got w_en=%0b waddr=%0d wdata=%0h, expected %0b %0d %0h",
                         c, w_en, waddr, wdata, exp_wen, exp_waddr, exp_wdata);
            end
            if (c < 390) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!drv_valid[i] && ($urandom % 3 != 0)) begin
                        drv_valid[i] = 1'b1;
                        drv_addr[i]  = 5'($urandom_range(0, 31));
                        drv_data[i]  = $urandom;
                    end
                end
            end
        end
        drv_valid = '0;
        apply_drive();
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (tb_rf[i] !== exp_rf[i]) begin
                errors++;
                $display("FAIL rand_rf[%0d]: got %0h, expected %0h", i, tb_rf[i], exp_rf[i]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({w_en, waddr} !== {1'b1, 5'd9}) begin
            errors++;
            $display("FAIL mid_clear_pos: got w_en=%0b waddr=%0d, expected 1 9", w_en, waddr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({w_en, waddr, wdata, clr_done, busy, req_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL mid_clear_rst: got w_en=%0b waddr=%0d wdata=%0h clr_done=%0b busy=%0b ready=%b",
                     w_en, waddr, wdata, clr_done, busy, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({w_en, waddr, clr_done} !== {1'b1, 5'(i), (i == 31)}) begin
                errors++;
                $display("FAIL mid_clear_restart[%0d]: got w_en=%0b waddr=%0d clr_done=%0b, expected 1 %0d %0b",
                         i, w_en, waddr, clr_done, i, (i == 31));
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, w_en} !== 2'b00) begin
            errors++;
            $display("FAIL mid_clear_end: got busy=%0b w_en=%0b, expected 0 0", busy, w_en);
        end
        m_ptr = NREQ - 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_addr_zero();
        test_clear_cmd();
        test_random();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
